apu_req_queue: RTL and testbench



---
 rtl/apu_req_queue.sv | 122 ++++++++++++
 tb/tb_apu_req_queue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_req_queue.sv
// Per-core request decoupling FIFO toward the shared APU cluster, with in-flight
// credit tracking and a sticky error for unaccounted results.
module apu_req_queue #(
    parameter int WOP_CPU         = 6,
    parameter int WAPUTYPE        = 6,
    parameter int NARGS_CPU       = 3,
    parameter int NDSFLAGS_CPU    = 15,
    parameter int NUSFLAGS_CPU    = 5,
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   apu_master_req_i,
    output logic                                   apu_master_gnt_o,
    input  logic [NARGS_CPU*32-1:0]                apu_master_operands_i,
    input  logic [WOP_CPU-1:0]                     apu_master_op_i,
    input  logic [WAPUTYPE-1:0]                    apu_master_type_i,
    input  logic [NDSFLAGS_CPU-1:0]                apu_master_flags_i,
    output logic                                   apu_master_valid_o,
    output logic [31:0]                            apu_master_result_o,
    output logic [NUSFLAGS_CPU-1:0]                apu_master_flags_o,
    input  logic                                   apu_master_ready_i,
    output logic                                   req_ds_s_o,
    input  logic                                   ack_ds_s_i,
    output logic [NARGS_CPU*32-1:0]                operands_ds_d_o,
    output logic [WOP_CPU-1:0]                     op_ds_d_o,
    output logic [WAPUTYPE-1:0]                    type_ds_d_o,
    output logic [NDSFLAGS_CPU-1:0]                flags_ds_d_o,
    output logic                                   tag_ds_d_o,
    input  logic                                   valid_us_s_i,
    input  logic [31:0]                            result_us_d_i,
    input  logic [NUSFLAGS_CPU-1:0]                flags_us_d_i,
    output logic                                   ready_us_s_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   busy_o,
    output logic                                   err_o
);

    localparam int PAY_W = NARGS_CPU*32 + WOP_CPU + WAPUTYPE + NDSFLAGS_CPU;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);

    logic [PAY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] outstanding;
    logic             err;

    logic             push, pop, resp;
    logic [PAY_W-1:0] payload_in, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant is qualified by rst_ni so the core sees no grant while reset is held.
    assign push = rst_ni && apu_master_req_i
                  && (count < CNT_W'(DEPTH))
                  && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign pop  = (count != '0) && ack_ds_s_i;
    assign resp = valid_us_s_i && apu_master_ready_i;

    assign payload_in = {apu_master_operands_i, apu_master_op_i,
                         apu_master_type_i, apu_master_flags_i};

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= payload_in;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A result with nothing in flight is flagged but never underflows the counter.
            if (push && !resp) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!push && resp && (outstanding != '0)) begin
                outstanding <= outstanding - OUT_W'(1);
            end
            if (resp && (outstanding == '0)) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is not reset, so the payload is masked to zero while the FIFO is empty.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

    assign apu_master_gnt_o = push;
    assign req_ds_s_o       = (count != '0);
    assign {operands_ds_d_o, op_ds_d_o, type_ds_d_o, flags_ds_d_o} = head;
    assign tag_ds_d_o       = 1'b0;

    assign apu_master_valid_o  = valid_us_s_i;
    assign apu_master_result_o = result_us_d_i;
    assign apu_master_flags_o  = flags_us_d_i;
    assign ready_us_s_o        = apu_master_ready_i;

    assign outstanding_o = outstanding;
    assign busy_o        = (outstanding != '0);
    assign err_o         = err;

endmodule

// File: tb/tb_apu_req_queue.sv
// Scoreboard bench for apu_req_queue: grants, FIFO order, credits, error and reset.
module tb_apu_req_queue;

    localparam int PAY_W = 96 + 6 + 6 + 15;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         apu_master_req_i;
    logic         apu_master_gnt_o;
    logic [95:0]  apu_master_operands_i;
    logic [5:0]   apu_master_op_i;
    logic [5:0]   apu_master_type_i;
    logic [14:0]  apu_master_flags_i;
    logic         apu_master_valid_o;
    logic [31:0]  apu_master_result_o;
    logic [4:0]   apu_master_flags_o;
    logic         apu_master_ready_i;
    logic         req_ds_s_o;
    logic         ack_ds_s_i;
    logic [95:0]  operands_ds_d_o;
    logic [5:0]   op_ds_d_o;
    logic [5:0]   type_ds_d_o;
    logic [14:0]  flags_ds_d_o;
    logic         tag_ds_d_o;
    logic         valid_us_s_i;
    logic [31:0]  result_us_d_i;
    logic [4:0]   flags_us_d_i;
    logic         ready_us_s_o;
    logic [2:0]   outstanding_o;
    logic         busy_o;
    logic         err_o;

    apu_req_queue dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .apu_master_req_i      (apu_master_req_i),
        .apu_master_gnt_o      (apu_master_gnt_o),
        .apu_master_operands_i (apu_master_operands_i),
        .apu_master_op_i       (apu_master_op_i),
        .apu_master_type_i     (apu_master_type_i),
        .apu_master_flags_i    (apu_master_flags_i),
        .apu_master_valid_o    (apu_master_valid_o),
        .apu_master_result_o   (apu_master_result_o),
        .apu_master_flags_o    (apu_master_flags_o),
        .apu_master_ready_i    (apu_master_ready_i),
        .req_ds_s_o            (req_ds_s_o),
        .ack_ds_s_i            (ack_ds_s_i),
        .operands_ds_d_o       (operands_ds_d_o),
        .op_ds_d_o             (op_ds_d_o),
        .type_ds_d_o           (type_ds_d_o),
        .flags_ds_d_o          (flags_ds_d_o),
        .tag_ds_d_o            (tag_ds_d_o),
        .valid_us_s_i          (valid_us_s_i),
        .result_us_d_i         (result_us_d_i),
        .flags_us_d_i          (flags_us_d_i),
        .ready_us_s_o          (ready_us_s_o),
        .outstanding_o         (outstanding_o),
        .busy_o                (busy_o),
        .err_o                 (err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [PAY_W-1:0] in_payload, ds_payload;
    assign in_payload = {apu_master_operands_i, apu_master_op_i, apu_master_type_i, apu_master_flags_i};
    assign ds_payload = {operands_ds_d_o, op_ds_d_o, type_ds_d_o, flags_ds_d_o};

    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_payload();
        seq++;
        apu_master_operands_i = {32'(seq * 3), 32'(seq * 7 + 1), 32'(seq) ^ 32'hA5A5_0000};
        apu_master_op_i       = 6'(seq);
        apu_master_type_i     = ~6'(seq);
        apu_master_flags_i    = 15'(seq) ^ 15'h5A5A;
        result_us_d_i         = 32'(seq) ^ 32'hC0DE_0000;
        flags_us_d_i          = 5'(seq * 5);
    endtask

    // Reference model, advanced on the falling edge with the inputs the bench drove.
    logic [PAY_W-1:0] exp_q[$];
    int  m_cnt = 0;
    int  m_out = 0;
    bit  m_err = 1'b0;
    bit  exp_gnt, m_pop, m_resp;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_cnt = 0;
            m_out = 0;
            m_err = 1'b0;
            exp_q.delete();
            check("rst_gnt", apu_master_gnt_o, 0);
            check("rst_req_ds", req_ds_s_o, 0);
            check("rst_outstanding", outstanding_o, 0);
            check("rst_payload", ds_payload, 0);
        end else begin
            exp_gnt = apu_master_req_i && (m_cnt < 2) && (m_out < 4);
            m_pop   = (m_cnt != 0) && ack_ds_s_i;
            m_resp  = valid_us_s_i && apu_master_ready_i;
            check("gnt", apu_master_gnt_o, exp_gnt);
            check("req_ds", req_ds_s_o, m_cnt != 0);
            check("outstanding", outstanding_o, m_out);
            check("busy", busy_o, m_out != 0);
            check("err", err_o, m_err);
            check("tag", tag_ds_d_o, 0);
            check("ready_us", ready_us_s_o, apu_master_ready_i);
            check("valid_pass", apu_master_valid_o, valid_us_s_i);
            check("result_pass", apu_master_result_o, result_us_d_i);
            check("rflags_pass", apu_master_flags_o, flags_us_d_i);
            if (m_cnt != 0) check("payload", ds_payload, exp_q[0]);
            else            check("payload_idle", ds_payload, 0);
            if (m_pop) void'(exp_q.pop_front());
            if (exp_gnt) exp_q.push_back(in_payload);
            m_cnt = m_cnt + int'(exp_gnt) - int'(m_pop);
            if (m_resp && m_out == 0) m_err = 1'b1;
            if (exp_gnt && !m_resp) m_out++;
            else if (!exp_gnt && m_resp && m_out != 0) m_out--;
        end
    end

    int grants;
    logic [PAY_W-1:0] rec;

    initial begin
        rst_ni = 1'b0;
        apu_master_req_i = 1'b1;
        apu_master_ready_i = 1'b1;
        ack_ds_s_i = 1'b0;
        valid_us_s_i = 1'b0;
        set_payload();
        repeat (3) cyc();
        check("reset_gnt", apu_master_gnt_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_err", err_o, 0);
        rst_ni = 1'b1;
        #1;
        check("gnt_after_release", apu_master_gnt_o, 1);
        cyc();
        apu_master_req_i = 1'b0; ack_ds_s_i = 1'b1;
        cyc();
        ack_ds_s_i = 1'b0; valid_us_s_i = 1'b1;
        cyc();
        valid_us_s_i = 1'b0;
        cyc();

        // back-to-back issue
        for (int i = 0; i < 12; i++) begin
            set_payload();
            apu_master_req_i = 1'b1; ack_ds_s_i = 1'b1; valid_us_s_i = (i >= 3);
            #1;
            check("b2b_gnt", apu_master_gnt_o, 1);
            check("b2b_req_ds", req_ds_s_o, i != 0);
            if (i >= 3) check("b2b_outstanding", outstanding_o, 3);
            cyc();
        end
        apu_master_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_payload(); valid_us_s_i = 1'b1;
            cyc();
        end
        valid_us_s_i = 1'b0; ack_ds_s_i = 1'b0;
        cyc();

        // backpressure
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            set_payload();
            apu_master_req_i = 1'b1;
            #1;
            if (apu_master_gnt_o) grants++;
            if (i == 0) rec = in_payload;
            else check("bp_head_hold", ds_payload, rec);
            cyc();
        end
        check("bp_grants", grants, 2);
        set_payload(); ack_ds_s_i = 1'b1;
        #1;
        check("bp_full_gnt", apu_master_gnt_o, 0);
        cyc();
        set_payload(); ack_ds_s_i = 1'b0;
        #1;
        check("bp_gnt_after_pop", apu_master_gnt_o, 1);
        cyc();
        apu_master_req_i = 1'b0; ack_ds_s_i = 1'b1;
        repeat (2) cyc();
        ack_ds_s_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_payload(); valid_us_s_i = 1'b1;
            cyc();
        end
        valid_us_s_i = 1'b0;
        cyc();

        // credit limit
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            set_payload();
            apu_master_req_i = 1'b1; ack_ds_s_i = 1'b1;
            #1;
            if (apu_master_gnt_o) grants++;
            cyc();
        end
        check("credit_grants", grants, 4);
        check("credit_busy", busy_o, 1);
        set_payload(); valid_us_s_i = 1'b1;
        #1;
        check("credit_block_gnt", apu_master_gnt_o, 0);
        cyc();
        set_payload(); valid_us_s_i = 1'b0;
        #1;
        check("credit_after_resp", outstanding_o, 3);
        check("credit_regrant", apu_master_gnt_o, 1);
        cyc();
        apu_master_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_payload(); valid_us_s_i = 1'b1;
            cyc();
        end
        valid_us_s_i = 1'b0;
        cyc();

        // simultaneous push and response at outstanding 2
        for (int i = 0; i < 2; i++) begin
            set_payload(); apu_master_req_i = 1'b1;
            cyc();
        end
        set_payload(); valid_us_s_i = 1'b1;
        cyc();
        apu_master_req_i = 1'b0; valid_us_s_i = 1'b0;
        #1;
        check("push_resp_out2", outstanding_o, 2);
        for (int i = 0; i < 2; i++) begin
            set_payload(); valid_us_s_i = 1'b1;
            cyc();
        end
        valid_us_s_i = 1'b0; ack_ds_s_i = 1'b0;

        // push and pop together with one entry held, over pointer wraps
        set_payload(); apu_master_req_i = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            set_payload(); ack_ds_s_i = 1'b1; valid_us_s_i = 1'b1;
            #1;
            check("wrap_gnt", apu_master_gnt_o, 1);
            check("wrap_req_ds", req_ds_s_o, 1);
            cyc();
        end
        apu_master_req_i = 1'b0;
        cyc();
        ack_ds_s_i = 1'b0; valid_us_s_i = 1'b0;
        #1;
        check("wrap_drained", req_ds_s_o, 0);
        check("wrap_out0", outstanding_o, 0);
        cyc();

        // unaccounted result
        set_payload(); valid_us_s_i = 1'b1; result_us_d_i = 32'hDEAD_BEEF;
        #1;
        check("err_result_visible", apu_master_result_o, 32'hDEAD_BEEF);
        cyc();
        valid_us_s_i = 1'b0;
        #1;
        check("err_set", err_o, 1);
        check("err_out0", outstanding_o, 0);
        repeat (3) cyc();
        check("err_sticky", err_o, 1);

        // reset during traffic: two entries queued, three outstanding
        set_payload(); apu_master_req_i = 1'b1; ack_ds_s_i = 1'b0;
        cyc();
        set_payload(); ack_ds_s_i = 1'b1;
        cyc();
        set_payload(); ack_ds_s_i = 1'b0;
        cyc();
        #1;
        check("pre_rst_out", outstanding_o, 3);
        check("pre_rst_req_ds", req_ds_s_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_gnt", apu_master_gnt_o, 0);
        check("midrst_req_ds", req_ds_s_o, 0);
        check("midrst_out", outstanding_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_payload", ds_payload, 0);
        repeat (2) cyc();
        rst_ni = 1'b1;
        #1;
        check("post_rst_gnt", apu_master_gnt_o, 1);
        cyc();
        apu_master_req_i = 1'b0;
        #1;
        check("post_rst_req_ds", req_ds_s_o, 1);
        ack_ds_s_i = 1'b1;
        cyc();
        ack_ds_s_i = 1'b0; set_payload(); valid_us_s_i = 1'b1;
        cyc();
        valid_us_s_i = 1'b0;
        cyc();
        check("final_err_clear", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
